// File: rtl/port_a_mode1_handshake_pkg.sv
// Shared types and defaults for the 8255-style port A mode 1 handshake block.
// Holds the FSM state encoding and default data/synchronizer sizes.
package ppi_pkg;

    localparam int PPI_DW          = 8;
    localparam int PPI_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        IN_EMPTY,
        IN_FULL,
        OUT_EMPTY,
        OUT_FULL
    } ppi_state_e;

    function automatic logic is_out(ppi_state_e s);
        return (s == OUT_EMPTY) || (s == OUT_FULL);
    endfunction

endpackage

// File: rtl/port_a_mode1_handshake_if.sv
// Port A bus bundle: peripheral/CPU strobes and data plus handshake flags.
// slave = the handshake block, master = the peripheral/CPU side.
interface port_a_mode1_handshake_if
    import ppi_pkg::*;
#(
    parameter int DW = PPI_DW
) ();

    logic          stb_n;
    logic          ack_n;
    logic          rd_a_n;
    logic          wr_a_n;
    logic [DW-1:0] pa_in;
    logic [DW-1:0] cpu_data;
    logic [DW-1:0] pa_latch;
    logic [DW-1:0] pa_out;
    logic          pa_oe;
    logic          ibf;
    logic          obf_n;
    logic          intr;
    logic          inte;

    modport slave (
        input  stb_n, ack_n, rd_a_n, wr_a_n, pa_in, cpu_data,
        output pa_latch, pa_out, pa_oe, ibf, obf_n, intr, inte
    );

    modport master (
        output stb_n, ack_n, rd_a_n, wr_a_n, pa_in, cpu_data,
        input  pa_latch, pa_out, pa_oe, ibf, obf_n, intr, inte
    );

endinterface

// File: rtl/port_a_mode1_handshake_sync_edge.sv
// Multi-flop synchronizer for an active-low strobe with rise/fall pulses.
// All stages reset to 1 so no edge is seen right after reset release.
module ppi_sync_edge
    import ppi_pkg::*;
#(
    parameter int STAGES = PPI_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/port_a_mode1_handshake.sv
// Port A mode 1 strobed I/O handshake (IBF/OBF/INTR/INTE).
// Optional PPI_OVERRUN_EN: keep first byte on overrun and flag it on ovr.
module port_a_mode1_handshake
    import ppi_pkg::*;
#(
    parameter int DW          = PPI_DW,
    parameter int SYNC_STAGES = PPI_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mode1_en,
    input  logic dir_in,
    input  logic inte_set,
    input  logic inte_clr,
`ifdef PPI_OVERRUN_EN
    output logic ovr,
`endif
    port_a_mode1_handshake_if.slave bus
);

    ppi_state_e    state_q, state_d;
    logic [DW-1:0] pa_dly_q [SYNC_STAGES];
    logic [DW-1:0] pa_dly_d [SYNC_STAGES];
    logic [DW-1:0] latch_q, latch_d;
    logic [DW-1:0] out_q, out_d;
    logic          intr_q, intr_d;
    logic          inte_q, inte_d;
    logic          armed_q, armed_d;
`ifdef PPI_OVERRUN_EN
    logic          ovr_q, ovr_d;
`endif

    logic stb_rise, stb_fall;
    logic ack_rise, ack_fall;
    logic rd_rise, rd_fall;
    logic wr_rise, wr_fall;

    ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_stb (
        .clk(clk), .rst_n(rst_n), .d(bus.stb_n),
        .rise(stb_rise), .fall(stb_fall)
    );

    ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_ack (
        .clk(clk), .rst_n(rst_n), .d(bus.ack_n),
        .rise(ack_rise), .fall(ack_fall)
    );

    ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_rd (
        .clk(clk), .rst_n(rst_n), .d(bus.rd_a_n),
        .rise(rd_rise), .fall(rd_fall)
    );

    ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_wr (
        .clk(clk), .rst_n(rst_n), .d(bus.wr_a_n),
        .rise(wr_rise), .fall(wr_fall)
    );

    // Data follows the same depth as stb_n so the captured byte matches the strobe.
    always_comb begin
        pa_dly_d[0] = bus.pa_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            pa_dly_d[i] = pa_dly_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        out_d   = out_q;
        intr_d  = intr_q;
        armed_d = armed_q;
`ifdef PPI_OVERRUN_EN
        ovr_d   = ovr_q;
`endif
        inte_d  = inte_q;
        if (inte_set) inte_d = 1'b1;
        if (inte_clr) inte_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mode1_en) state_d = dir_in ? IN_EMPTY : OUT_EMPTY;
            end
            IN_EMPTY: begin
                if (stb_fall) begin
                    latch_d = pa_dly_q[SYNC_STAGES-1];
                    state_d = IN_FULL;
                end
                if (rd_fall) intr_d = 1'b0;
            end
            IN_FULL: begin
                if (stb_fall) begin
`ifdef PPI_OVERRUN_EN
                    ovr_d   = 1'b1;
`else
                    latch_d = pa_dly_q[SYNC_STAGES-1];
`endif
                end else if (rd_rise) begin
                    state_d = IN_EMPTY;
`ifdef PPI_OVERRUN_EN
                    ovr_d   = 1'b0;
`endif
                end
                if (stb_rise && inte_q) intr_d = 1'b1;
                if (rd_fall) intr_d = 1'b0;
            end
            OUT_EMPTY, OUT_FULL: begin
                if (ack_rise && armed_q) begin
                    armed_d = 1'b0;
                    if (inte_q) intr_d = 1'b1;
                end
                if (wr_rise) begin
                    out_d   = bus.cpu_data;
                    intr_d  = 1'b0;
                    state_d = OUT_FULL;
                end else if (state_q == OUT_FULL && ack_fall) begin
                    armed_d = 1'b1;
                    state_d = OUT_EMPTY;
                end
                if (wr_fall) intr_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (inte_clr) intr_d = 1'b0;

        if (!mode1_en) begin
            state_d = IDLE;
            latch_d = '0;
            out_d   = '0;
            intr_d  = 1'b0;
            inte_d  = 1'b0;
            armed_d = 1'b0;
`ifdef PPI_OVERRUN_EN
            ovr_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            latch_q <= '0;
            out_q   <= '0;
            intr_q  <= 1'b0;
            inte_q  <= 1'b0;
            armed_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) pa_dly_q[i] <= '0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            out_q   <= out_d;
            intr_q  <= intr_d;
            inte_q  <= inte_d;
            armed_q <= armed_d;
            for (int i = 0; i < SYNC_STAGES; i++) pa_dly_q[i] <= pa_dly_d[i];
        end
    end

`ifdef PPI_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= 1'b0;
        else        ovr_q <= ovr_d;
    end

    assign ovr = ovr_q;
`endif

    assign bus.pa_latch = latch_q;
    assign bus.pa_out   = out_q;
    assign bus.pa_oe    = is_out(state_q);
    assign bus.ibf      = (state_q == IN_FULL);
    assign bus.obf_n    = (state_q != OUT_FULL);
    assign bus.intr     = intr_q;
    assign bus.inte     = inte_q;

endmodule

// File: tb/tb_port_a_mode1_handshake.sv
// Directed table plus hand sequences for the port A mode 1 handshake.
// Works with and without PPI_OVERRUN_EN defined.
module tb_port_a_mode1_handshake;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic mode1_en, dir_in, inte_set, inte_clr;
`ifdef PPI_OVERRUN_EN
    logic ovr;
`endif

    port_a_mode1_handshake_if #(.DW(8)) bus ();

    port_a_mode1_handshake #(.DW(8), .SYNC_STAGES(S)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mode1_en(mode1_en),
        .dir_in(dir_in),
        .inte_set(inte_set),
        .inte_clr(inte_clr),
`ifdef PPI_OVERRUN_EN
        .ovr(ovr),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       mode, dir, iset, iclr;
        logic       stb, ack, rd, wr;
        logic [7:0] pa, cpu;
        int         n;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic vec_t v(string nm,
        logic mode, logic dir, logic iset, logic iclr,
        logic stb, logic ack, logic rd, logic wr,
        logic [7:0] pa, logic [7:0] cpu, int n,
        logic ibf, logic obf, logic intr, logic inte, logic oe,
        logic [7:0] lat, logic [7:0] out);
        vec_t r;
        r.nm = nm; r.mode = mode; r.dir = dir; r.iset = iset; r.iclr = iclr;
        r.stb = stb; r.ack = ack; r.rd = rd; r.wr = wr;
        r.pa = pa; r.cpu = cpu; r.n = n;
        r.exp = {ibf, obf, intr, inte, oe, lat, out};
        return r;
    endfunction

    function automatic logic [20:0] outs();
        return {bus.ibf, bus.obf_n, bus.intr, bus.inte, bus.pa_oe,
                bus.pa_latch, bus.pa_out};
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [20:0] act, logic [20:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // ibf obf intr inte oe latch out
        tbl.push_back(v("rst_idle",  0,0,0,0, 1,1,1,1, 8'h00,8'h00,2, 0,1,0,0,0,8'h00,8'h00));
        tbl.push_back(v("in_mode",   1,1,0,0, 1,1,1,1, 8'h00,8'h00,2, 0,1,0,0,0,8'h00,8'h00));
        tbl.push_back(v("inte_set",  1,1,1,0, 1,1,1,1, 8'h00,8'h00,2, 0,1,0,1,0,8'h00,8'h00));
        tbl.push_back(v("stb_fall",  1,1,0,0, 0,1,1,1, 8'hA5,8'h00,4, 1,1,0,1,0,8'hA5,8'h00));
        tbl.push_back(v("stb_rise",  1,1,0,0, 1,1,1,1, 8'hA5,8'h00,4, 1,1,1,1,0,8'hA5,8'h00));
        tbl.push_back(v("rd_fall",   1,1,0,0, 1,1,0,1, 8'hA5,8'h00,4, 1,1,0,1,0,8'hA5,8'h00));
        tbl.push_back(v("rd_rise",   1,1,0,0, 1,1,1,1, 8'hA5,8'h00,4, 0,1,0,1,0,8'hA5,8'h00));
        tbl.push_back(v("inte_clr",  1,1,0,1, 1,1,1,1, 8'hA5,8'h00,2, 0,1,0,0,0,8'hA5,8'h00));
        tbl.push_back(v("stb_fl_g",  1,1,0,0, 0,1,1,1, 8'h5A,8'h00,4, 1,1,0,0,0,8'h5A,8'h00));
        tbl.push_back(v("stb_rs_g",  1,1,0,0, 1,1,1,1, 8'h5A,8'h00,4, 1,1,0,0,0,8'h5A,8'h00));
        tbl.push_back(v("rd_fl_g",   1,1,0,0, 1,1,0,1, 8'h5A,8'h00,4, 1,1,0,0,0,8'h5A,8'h00));
        tbl.push_back(v("rd_rs_g",   1,1,0,0, 1,1,1,1, 8'h5A,8'h00,4, 0,1,0,0,0,8'h5A,8'h00));
        tbl.push_back(v("ack_ign0",  1,1,0,0, 1,0,1,1, 8'h5A,8'h00,4, 0,1,0,0,0,8'h5A,8'h00));
        tbl.push_back(v("ack_ign1",  1,1,0,0, 1,1,1,1, 8'h5A,8'h00,4, 0,1,0,0,0,8'h5A,8'h00));
        tbl.push_back(v("wr_ign0",   1,1,0,0, 1,1,1,0, 8'h5A,8'h99,4, 0,1,0,0,0,8'h5A,8'h00));
        tbl.push_back(v("wr_ign1",   1,1,0,0, 1,1,1,1, 8'h5A,8'h99,4, 0,1,0,0,0,8'h5A,8'h00));
        tbl.push_back(v("mode_off",  0,1,0,0, 1,1,1,1, 8'h5A,8'h99,2, 0,1,0,0,0,8'h00,8'h00));
        tbl.push_back(v("out_mode",  1,0,0,0, 1,1,1,1, 8'h00,8'h00,2, 0,1,0,0,1,8'h00,8'h00));
        tbl.push_back(v("inte_set2", 1,0,1,0, 1,1,1,1, 8'h00,8'h00,2, 0,1,0,1,1,8'h00,8'h00));
        tbl.push_back(v("wr_fall",   1,0,0,0, 1,1,1,0, 8'h00,8'h3C,4, 0,1,0,1,1,8'h00,8'h00));
        tbl.push_back(v("wr_rise",   1,0,0,0, 1,1,1,1, 8'h00,8'h3C,4, 0,0,0,1,1,8'h00,8'h3C));
        tbl.push_back(v("ack_fall",  1,0,0,0, 1,0,1,1, 8'h00,8'h3C,4, 0,1,0,1,1,8'h00,8'h3C));
        tbl.push_back(v("ack_rise",  1,0,0,0, 1,1,1,1, 8'h00,8'h3C,4, 0,1,1,1,1,8'h00,8'h3C));
        tbl.push_back(v("inte_clr2", 1,0,0,1, 1,1,1,1, 8'h00,8'h3C,2, 0,1,0,0,1,8'h00,8'h3C));
        tbl.push_back(v("wr2_fall",  1,0,0,0, 1,1,1,0, 8'h00,8'hC3,4, 0,1,0,0,1,8'h00,8'h3C));
        tbl.push_back(v("wr2_rise",  1,0,0,0, 1,1,1,1, 8'h00,8'hC3,4, 0,0,0,0,1,8'h00,8'hC3));
        tbl.push_back(v("stb_ign0",  1,0,0,0, 0,1,1,1, 8'h66,8'hC3,4, 0,0,0,0,1,8'h00,8'hC3));
        tbl.push_back(v("stb_ign1",  1,0,0,0, 1,1,1,1, 8'h66,8'hC3,4, 0,0,0,0,1,8'h00,8'hC3));
        tbl.push_back(v("rd_ign0",   1,0,0,0, 1,1,0,1, 8'h66,8'hC3,4, 0,0,0,0,1,8'h00,8'hC3));
        tbl.push_back(v("rd_ign1",   1,0,0,0, 1,1,1,1, 8'h66,8'hC3,4, 0,0,0,0,1,8'h00,8'hC3));
        tbl.push_back(v("ack2_fall", 1,0,0,0, 1,0,1,1, 8'h66,8'hC3,4, 0,1,0,0,1,8'h00,8'hC3));
        tbl.push_back(v("ack2_rise", 1,0,0,0, 1,1,1,1, 8'h66,8'hC3,4, 0,1,0,0,1,8'h00,8'hC3));
        tbl.push_back(v("inte_set3", 1,0,1,0, 1,1,1,1, 8'h66,8'hC3,2, 0,1,0,1,1,8'h00,8'hC3));
        tbl.push_back(v("inte_both", 1,0,1,1, 1,1,1,1, 8'h66,8'hC3,2, 0,1,0,0,1,8'h00,8'hC3));

        rst_n = 1'b0;
        mode1_en = 1'b0; dir_in = 1'b0; inte_set = 1'b0; inte_clr = 1'b0;
        bus.stb_n = 1'b1; bus.ack_n = 1'b1; bus.rd_a_n = 1'b1; bus.wr_a_n = 1'b1;
        bus.pa_in = 8'h00; bus.cpu_data = 8'h00;
        tick(2);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            mode1_en = tbl[k].mode; dir_in = tbl[k].dir;
            inte_set = tbl[k].iset; inte_clr = tbl[k].iclr;
            bus.stb_n = tbl[k].stb; bus.ack_n = tbl[k].ack;
            bus.rd_a_n = tbl[k].rd; bus.wr_a_n = tbl[k].wr;
            bus.pa_in = tbl[k].pa; bus.cpu_data = tbl[k].cpu;
            tick(1);
            inte_set = 1'b0; inte_clr = 1'b0;
            tick(tbl[k].n - 1);
            chk(tbl[k].nm, outs(), tbl[k].exp);
        end

        // Reset asserted while OUT_FULL takes effect without a clock.
        inte_set = 1'b1; tick(1); inte_set = 1'b0; tick(1);
        bus.cpu_data = 8'h77;
        bus.wr_a_n = 1'b0; tick(4);
        bus.wr_a_n = 1'b1; tick(4);
        chk("pre_rst", outs(), {5'b00011, 8'h00, 8'h77});
        rst_n = 1'b0;
        #1;
        chk("async_rst", outs(), {5'b01000, 8'h00, 8'h00});
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst", outs(), {5'b01001, 8'h00, 8'h00});

        // Capture latency and mode exit from IN_FULL.
        mode1_en = 1'b0; tick(2);
        mode1_en = 1'b1; dir_in = 1'b1; tick(2);
        bus.pa_in = 8'hE7; bus.stb_n = 1'b0;
        tick(S);
        chk("ibf_early", outs(), {5'b01000, 8'h00, 8'h00});
        tick(1);
        chk("ibf_latency", outs(), {5'b11000, 8'hE7, 8'h00});
        mode1_en = 1'b0;
        tick(1);
        chk("mode_exit", outs(), {5'b01000, 8'h00, 8'h00});
        bus.stb_n = 1'b1; tick(4);

        // stb_n fall coincident with rd_a_n rise.
        mode1_en = 1'b1; dir_in = 1'b1; tick(2);
        bus.pa_in = 8'h22; bus.stb_n = 1'b0; tick(4);
        bus.stb_n = 1'b1; tick(4);
        chk("col_first", outs(), {5'b11000, 8'h22, 8'h00});
        bus.rd_a_n = 1'b0; tick(4);
        bus.pa_in = 8'h11; bus.stb_n = 1'b0; bus.rd_a_n = 1'b1; tick(4);
`ifdef PPI_OVERRUN_EN
        chk("collision", outs(), {5'b11000, 8'h22, 8'h00});
        chk("ovr_set", {20'h0, ovr}, 21'h1);
`else
        chk("collision", outs(), {5'b11000, 8'h11, 8'h00});
`endif
        bus.stb_n = 1'b1; tick(4);
        bus.rd_a_n = 1'b0; tick(4);
        bus.rd_a_n = 1'b1; tick(4);
`ifdef PPI_OVERRUN_EN
        chk("ovr_clr", {20'h0, ovr}, 21'h0);
        chk("col_drain", outs(), {5'b01000, 8'h22, 8'h00});
`else
        chk("col_drain", outs(), {5'b01000, 8'h11, 8'h00});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
